seven_segment_scan: RTL and testbench

//   Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus.

---
 rtl/seven_segment_scan.sv | 146 ++++++++++++++
 tb/tb_seven_segment_scan.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan.sv
// Multiplexed common-anode seven-segment driver.
// Double-buffered display value, BCD/hex decode, leading-zero blanking.
module seven_segment_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_en,
  input  logic                    lz_blank_en,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   act_dp;

  logic                    cnt_wrap;
  logic                    idx_last;
  logic                    frame_wrap;
  logic                    in_blank;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   zero_above;
  logic                    run_zero;
  logic [6:0]              seg_d;
  logic                    dp_d;
  logic [NUM_DIGITS-1:0]   an_d;

  function automatic logic [6:0] decode(
    input logic [3:0] n,
    input logic       hex
  );
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    if (!hex && n > 4'd9) s = SEG_OFF;
    return s;
  endfunction

  assign cnt_wrap   = (cnt == CW'(REFRESH_DIV - 1));
  assign idx_last   = (idx == IW'(NUM_DIGITS - 1));
  assign frame_wrap = cnt_wrap && idx_last;
  assign in_blank   = ({1'b0, cnt} < (CW+1)'(BLANK_CYCLES));
  assign nib        = act_val[4*idx +: 4];

  // zero_above[i]: nibble i and every higher nibble are zero
  always_comb begin
    zero_above = '0;
    run_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero      = run_zero && (act_val[4*i +: 4] == 4'h0);
      zero_above[i] = run_zero;
    end
  end

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = '1;
    if (!in_blank) begin
      an_d[idx] = 1'b0;
      dp_d      = ~act_dp[idx];
      if (lz_blank_en && idx != '0 && zero_above[idx])
        seg_d = SEG_OFF;
      else
        seg_d = decode(nib, hex_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap)
        idx <= idx_last ? '0 : idx + IW'(1);
    end
  end

  // Old pending moves on the wrap; a coincident load stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
    end else begin
      if (frame_wrap && pend_valid) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end else if (frame_wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= SEG_OFF;
      dp_out  <= 1'b1;
      an_out  <= '1;
    end else begin
      seg_out <= seg_d;
      dp_out  <= dp_d;
      an_out  <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: edge-count display model plus
// directed literal checks on decoded digits, buffering and timing.
module tb_seven_segment_scan;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BLK = 1;
  localparam int FR  = N * DIV;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  value = '0;
  logic [3:0]   dp_in = '0;
  logic         load = 1'b0;
  logic         hex_en = 1'b0;
  logic         lz_blank_en = 1'b0;
  logic [6:0]   seg_out;
  logic         dp_out;
  logic [3:0]   an_out;

  int checks = 0;
  int errors = 0;

  seven_segment_scan #(
    .NUM_DIGITS(N),
    .REFRESH_DIV(DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .dp_in(dp_in),
    .load(load),
    .hex_en(hex_en),
    .lz_blank_en(lz_blank_en),
    .seg_out(seg_out),
    .dp_out(dp_out),
    .an_out(an_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d, input bit hex);
    if (d > 9 && !hex) return 7'h7F;
    return GLYPH[d];
  endfunction

  // Model: position in scan derived from number of edges since reset
  int          edges = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_adp = '0;
  logic [3:0]  m_pdp = '0;
  bit          m_pv = 1'b0;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic [3:0]  e_an = 4'hF;

  always @(posedge clk or posedge rst) begin
    int c, i, d;
    if (rst) begin
      edges = 0;
      m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pv = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end else begin
      c = edges % DIV;
      i = (edges / DIV) % N;
      if (c < BLK) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end else begin
        e_an = 4'hF & ~(4'b1 << i);
        e_dp = !m_adp[i];
        d = int'((m_act >> (4*i)) & 16'hF);
        if (lz_blank_en && i > 0 && (m_act >> (4*i)) == 16'h0)
          e_seg = 7'h7F;
        else
          e_seg = glyph(d, hex_en);
      end
      if (edges % FR == FR - 1) begin
        if (m_pv) begin
          m_act = m_pend; m_adp = m_pdp;
        end
        m_pv = 1'b0;
      end
      if (load) begin
        m_pend = value; m_pdp = dp_in; m_pv = 1'b1;
      end
      edges++;
    end
  end

  always @(negedge clk) begin
    chk("model_seg", 32'(seg_out), 32'(e_seg));
    chk("model_dp", 32'(dp_out), 32'(e_dp));
    chk("model_an", 32'(an_out), 32'(e_an));
    chk("one_anode", 32'($countones(~an_out) <= 1), 32'd1);
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Next fresh occurrence of a given anode pattern, then literal checks
  task automatic expect_digit(input logic [3:0] an, input logic [6:0] seg,
                              input logic dp, input string nm);
    int n = 0;
    while (an_out == an && n < 40) begin @(negedge clk); n++; end
    while (an_out != an && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      chk({nm, "_timeout"}, 32'(an_out), 32'(an));
    end else begin
      chk({nm, "_seg"}, 32'(seg_out), 32'(seg));
      chk({nm, "_dp"}, 32'(dp_out), 32'(dp));
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_dp", 32'(dp_out), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    expect_digit(4'hE, 7'b0000001, 1'b1, "rst_d0");
    expect_digit(4'h7, 7'b0000001, 1'b1, "rst_d3");

    do_load(16'h1234, 4'b0100);
    repeat (32) @(negedge clk);
    expect_digit(4'hE, 7'b1001100, 1'b1, "bcd_d0");
    expect_digit(4'hD, 7'b0000110, 1'b1, "bcd_d1");
    expect_digit(4'hB, 7'b0010010, 1'b0, "bcd_d2");
    expect_digit(4'h7, 7'b1001111, 1'b1, "bcd_d3");

    hex_en = 1'b1;
    do_load(16'hBEEF, 4'b0000);
    repeat (32) @(negedge clk);
    expect_digit(4'hE, 7'b0111000, 1'b1, "hex_d0");
    expect_digit(4'hD, 7'b0110000, 1'b1, "hex_d1");
    expect_digit(4'h7, 7'b1100000, 1'b1, "hex_d3");
    hex_en = 1'b0;
    expect_digit(4'hE, 7'h7F, 1'b1, "bcdblank_d0");
    expect_digit(4'h7, 7'h7F, 1'b1, "bcdblank_d3");

    lz_blank_en = 1'b1;
    do_load(16'h0050, 4'b0000);
    repeat (32) @(negedge clk);
    expect_digit(4'h7, 7'h7F, 1'b1, "lz_d3");
    expect_digit(4'hB, 7'h7F, 1'b1, "lz_d2");
    expect_digit(4'hD, 7'b0100100, 1'b1, "lz_d1");
    expect_digit(4'hE, 7'b0000001, 1'b1, "lz_d0");
    do_load(16'h0000, 4'b0010);
    repeat (32) @(negedge clk);
    expect_digit(4'hD, 7'h7F, 1'b0, "lz0_d1");
    expect_digit(4'hE, 7'b0000001, 1'b1, "lz0_d0");
    lz_blank_en = 1'b0;

    do_load(16'h1111, 4'b0000);
    repeat (32) @(negedge clk);
    n = 0;
    while (edges % FR != 6 && n < 40) begin @(negedge clk); n++; end
    do_load(16'h2222, 4'b0000);
    repeat (32) @(negedge clk);
    expect_digit(4'hE, 7'b0010010, 1'b1, "tear_d0");
    n = 0;
    while (edges % FR != FR - 1 && n < 40) begin @(negedge clk); n++; end
    do_load(16'h4444, 4'b0000);
    expect_digit(4'hE, 7'b0010010, 1'b1, "wrapload_old");
    expect_digit(4'hE, 7'b1001100, 1'b1, "wrapload_new");

    n = 0;
    do begin @(negedge clk); n++; end while (an_out == 4'hE && n < 40);
    do begin @(negedge clk); n++; end while (an_out != 4'hE && n < 40);
    chk("period", 32'(n), 32'd16);
    repeat (48) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
